// File: rtl/edge_det_bank.sv
// Multi-channel edge detector: per-channel synchroniser, debounce window,
// mode-qualified one-cycle edge pulse and sticky event flag.
module edge_det_bank #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS-1:0]   in,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [DEBOUNCE_W-1:0] db_limit,
    input  logic [CHANNELS-1:0]   clr,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   pulse,
    output logic [CHANNELS-1:0]   sticky,
    output logic                  any
);

    logic [CHANNELS-1:0]   sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0]   sync;
    logic [DEBOUNCE_W-1:0] cnt_q  [CHANNELS];
    logic [DEBOUNCE_W-1:0] cnt_d  [CHANNELS];
    logic [CHANNELS-1:0]   level_d;
    logic [CHANNELS-1:0]   pulse_d;
    logic [CHANNELS-1:0]   sticky_d;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // The counter only advances while below db_limit, so it can never wrap;
    // lowering db_limit mid-count commits on the next mismatching edge.
    always_comb begin
        level_d = level;
        pulse_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync[i] == level[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= db_limit) begin
                level_d[i] = sync[i];
                cnt_d[i]   = '0;
                pulse_d[i] = (sync[i] & mode[2*i]) | (~sync[i] & mode[2*i+1]);
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        // A new event beats a simultaneous clear so nothing is lost.
        sticky_d = pulse_d | (sticky & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
            level  <= '0;
            pulse  <= '0;
            sticky <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
            level  <= level_d;
            pulse  <= pulse_d;
            sticky <= sticky_d;
        end
    end

    assign any = |sticky;

endmodule

// File: tb/tb_edge_det_bank.sv
// Self-checking bench for edge_det_bank: cycle-level reference model feeding an
// expected queue, plus directed pulse-count and async-reset checks.
module tb_edge_det_bank;

    localparam int CH = 4;
    localparam int W  = 3*CH + 1;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] in;
    logic [2*CH-1:0] mode;
    logic [3:0]    db_limit;
    logic [CH-1:0] clr;
    logic [CH-1:0] level, pulse, sticky;
    logic          any;

    edge_det_bank #(.CHANNELS(CH), .SYNC_STAGES(2), .DEBOUNCE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .mode(mode), .db_limit(db_limit),
        .clr(clr), .level(level), .pulse(pulse), .sticky(sticky), .any(any)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];
    int pulse_cnt[CH];

    // reference model state
    logic [CH-1:0] m_s0, m_s1, m_level, m_pulse, m_sticky;
    int            m_run[CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_clear();
        m_s0 = '0; m_s1 = '0; m_level = '0; m_pulse = '0; m_sticky = '0;
        for (int i = 0; i < CH; i++) m_run[i] = 0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        logic [CH-1:0] s;
        logic [CH-1:0] np;
        if (!rst_n) begin
            model_clear();
            return;
        end
        s  = m_s1;
        np = '0;
        for (int i = 0; i < CH; i++) begin
            if (s[i] == m_level[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i]++;
                if (m_run[i] > int'(db_limit)) begin
                    m_level[i] = s[i];
                    m_run[i]   = 0;
                    if (s[i]) np[i] = mode[2*i];
                    else      np[i] = mode[2*i+1];
                end
            end
        end
        m_sticky = np | (m_sticky & ~clr);
        m_pulse  = np;
        m_s1     = m_s0;
        m_s0     = in;
    endtask

    // driver: one clock with scoreboard push/pop
    task automatic cycle(input string tag);
        logic [W-1:0] got;
        model_step();
        exp_q.push_back({m_level, m_pulse, m_sticky, |m_sticky});
        @(posedge clk);
        #1;
        got = {level, pulse, sticky, any};
        check(tag, 32'(got), 32'(exp_q.pop_front()));
        for (int i = 0; i < CH; i++) pulse_cnt[i] += int'(pulse[i]);
    endtask

    task automatic cycles(input string tag, input int n);
        for (int k = 0; k < n; k++) cycle(tag);
    endtask

    task automatic zero_counts();
        for (int i = 0; i < CH; i++) pulse_cnt[i] = 0;
    endtask

    initial begin
        model_clear();
        zero_counts();
        rst_n = 1'b0; in = '0; mode = 8'hFF; db_limit = '0; clr = '0;
        #1;
        check("reset_outputs", 32'({level, pulse, sticky, any}), 32'd0);
        @(posedge clk); #1;

        // 1: held in reset with toggling inputs
        for (int k = 0; k < 6; k++) begin
            in = CH'($urandom_range(0, 15));
            cycle("s1_reset_hold");
        end
        in = '0;
        rst_n = 1'b1;
        cycles("s1_idle", 4);

        // 2: ch0 rise only, no debounce
        zero_counts();
        mode = 8'h01; db_limit = 4'd0;
        in[0] = 1'b1;
        cycle("s2_e1"); cycle("s2_e2");
        check("s2_no_pulse_before_e3", 32'(pulse[0]), 32'd0);
        cycle("s2_e3");
        check("s2_pulse_at_e3", 32'(pulse[0]), 32'd1);
        check("s2_any", 32'(any), 32'd1);
        cycles("s2_hold", 3);
        in[0] = 1'b0;
        cycles("s2_fall", 5);
        check("s2_level_low", 32'(level[0]), 32'd0);
        check("s2_pulse_count", 32'(pulse_cnt[0]), 32'd1);

        // 4: sticky clear vs. set on the same edge
        clr = '1; cycle("s4_clr_all"); clr = '0;
        check("s4_cleared", 32'(sticky), 32'd0);
        in[0] = 1'b1;
        cycle("s4_e1"); cycle("s4_e2");
        clr[0] = 1'b1;
        cycle("s4_pulse_edge");
        check("s4_set_wins", 32'(sticky[0]), 32'd1);
        cycle("s4_clr_edge");
        check("s4_sticky_cleared", 32'(sticky[0]), 32'd0);
        check("s4_any_low", 32'(any), 32'd0);
        clr = '0; in[0] = 1'b0;
        cycles("s4_settle", 4);

        // 3: ch1 both edges, db_limit=3, glitch rejection
        zero_counts();
        mode = 8'h0C; db_limit = 4'd3;
        in[1] = 1'b1; cycles("s3_glitch", 3);
        in[1] = 1'b0; cycles("s3_glitch_end", 6);
        check("s3_glitch_no_level", 32'(level[1]), 32'd0);
        check("s3_glitch_no_pulse", 32'(pulse_cnt[1]), 32'd0);
        in[1] = 1'b1;
        cycles("s3_rise_pre", 5);
        check("s3_no_pulse_e5", 32'(pulse[1]), 32'd0);
        cycle("s3_rise_e6");
        check("s3_pulse_e6", 32'(pulse[1]), 32'd1);
        cycles("s3_rise_hold", 3);
        in[1] = 1'b0;
        cycles("s3_fall_pre", 5);
        cycle("s3_fall_e6");
        check("s3_fall_pulse_e6", 32'(pulse[1]), 32'd1);
        cycles("s3_fall_hold", 3);
        check("s3_pulse_count", 32'(pulse_cnt[1]), 32'd2);

        // 5: ch2 fall only, ch3 off
        zero_counts();
        clr = '1; cycle("s5_clr"); clr = '0;
        mode = 8'h20; db_limit = 4'd0;
        in[3:2] = 2'b11; cycles("s5_high", 6);
        check("s5_ch3_level_high", 32'(level[3]), 32'd1);
        in[3:2] = 2'b00; cycles("s5_low", 6);
        check("s5_ch2_pulses", 32'(pulse_cnt[2]), 32'd1);
        check("s5_ch3_pulses", 32'(pulse_cnt[3]), 32'd0);
        check("s5_ch3_sticky", 32'(sticky[3]), 32'd0);

        // 6: async reset mid-debounce discards the pending transition
        zero_counts();
        mode = 8'h01; db_limit = 4'd5;
        in[0] = 1'b1;
        cycles("s6_count", 4);
        rst_n = 1'b0;
        #1;
        check("s6_async_clear", 32'({level, pulse, sticky, any}), 32'd0);
        model_clear();
        cycle("s6_in_reset");
        rst_n = 1'b1;
        cycles("s6_pre", 7);
        check("s6_no_pulse_e7", 32'(pulse[0]), 32'd0);
        cycle("s6_e8");
        check("s6_pulse_e8", 32'(pulse[0]), 32'd1);
        cycles("s6_after", 3);

        // randomised soak against the model
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) in = CH'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) mode = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) db_limit = 4'($urandom_range(0, 4));
            clr = ($urandom_range(0, 7) == 0) ? CH'($urandom_range(0, 15)) : '0;
            cycle("rand");
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
